rpn_sequencer: RTL and testbench

Controller that sequences the RPN stack datapath. It accepts a stream of tokens (push value, operator, end-of-expression) through a valid/ready interface and buffers them in a small FIFO. It issues one datapath step per token and keeps a shadow stack depth so it can reject underflow and overflow before they reach the datapath. For each expression it returns one result, or an error code, on a valid/ready result port.

---
 rtl/rpn_sequencer_if.sv | 21 ++
 rtl/rpn_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_rpn_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_sequencer_if.sv
// Token-in and result-out handshake bundle for rpn_sequencer.
// The sequencer takes the slave side; the token source / result sink takes master.
interface rpn_sequencer_if;
    logic        tok_valid;
    logic        tok_ready;
    logic [17:0] tok_data;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [2:0]  res_err;

    modport master (
        output tok_valid, tok_data, res_ready,
        input  tok_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  tok_valid, tok_data, res_ready,
        output tok_ready, res_valid, res_data, res_err
    );
endinterface

// File: rtl/rpn_sequencer.sv
// Sequencer for the RPN stack datapath: buffers tokens, checks a shadow depth and returns one result per expression.
// Optional macro RPN_SEQ_STATS_EN adds saturating stat_ok / stat_err result counters.
module rpn_sequencer #(
    parameter int DEPTH      = 1024,
    parameter int FIFO_DEPTH = 8,
    parameter int DP_LAT     = 1
) (
    input  logic          clk,
    input  logic          rst,
    rpn_sequencer_if.slave bus,
    output logic          dp_step,
    output logic          dp_push,
    output logic [1:0]    dp_op,
    output logic [15:0]   dp_d,
    input  logic [15:0]   dp_out,
    output logic          dp_clr,
    output logic          busy
`ifdef RPN_SEQ_STATS_EN
    ,
    output logic [15:0]   stat_ok,
    output logic [15:0]   stat_err
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int DW = $clog2(DEPTH) + 1;
    localparam int WW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

    localparam logic [1:0] K_PUSH = 2'b00;
    localparam logic [1:0] K_OP   = 2'b01;
    localparam logic [1:0] K_END  = 2'b10;

    typedef enum logic [2:0] {FETCH, ISSUE, WAIT, RESULT, DRAIN} state_t;

    state_t        state, nxt;
    logic [17:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [17:0]   head, tok_q;
    logic          empty, full, wr_en, rd_en, hs, boot;
    logic [DW-1:0] depth, depth_n;
    logic [2:0]    err_q, err_n, res_err_q;
    logic [15:0]   res_data_q;
    logic [WW-1:0] wcnt;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];
    assign wr_en = bus.tok_valid && !full;
    assign hs    = (state == RESULT) && bus.res_ready;

    assign bus.tok_ready = !full;
    assign bus.res_valid = (state == RESULT);
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = res_err_q;
    assign busy          = (state != FETCH) || !empty;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= bus.tok_data;
    end

    always_ff @(posedge clk) begin
        if (rd_en) tok_q <= head;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= nxt;
    end

    always_comb begin
        nxt     = state;
        rd_en   = 1'b0;
        dp_step = 1'b0;
        dp_push = 1'b0;
        dp_op   = 2'd0;
        dp_d    = 16'd0;
        err_n   = err_q;
        depth_n = depth;
        case (state)
            FETCH: begin
                if (!empty) begin
                    rd_en = 1'b1;
                    nxt   = ISSUE;
                end
            end
            ISSUE: begin
                nxt = WAIT;
                case (tok_q[17:16])
                    K_PUSH: begin
                        if (depth == DW'(DEPTH)) begin
                            err_n = 3'd2;
                            nxt   = DRAIN;
                        end else begin
                            dp_step = 1'b1;
                            dp_push = 1'b1;
                            dp_d    = tok_q[15:0];
                            depth_n = depth + DW'(1);
                        end
                    end
                    K_OP: begin
                        case (tok_q[1:0])
                            2'd0: dp_step = 1'b1;
                            2'd1: begin
                                if (depth < DW'(1)) begin
                                    err_n = 3'd1;
                                    nxt   = DRAIN;
                                end else begin
                                    dp_step = 1'b1;
                                    dp_op   = 2'd1;
                                end
                            end
                            default: begin
                                if (depth < DW'(2)) begin
                                    err_n = 3'd1;
                                    nxt   = DRAIN;
                                end else begin
                                    dp_step = 1'b1;
                                    dp_op   = tok_q[1:0];
                                    depth_n = depth - DW'(1);
                                end
                            end
                        endcase
                    end
                    K_END: begin
                        nxt   = RESULT;
                        err_n = (depth == DW'(1)) ? 3'd0 : 3'd4;
                    end
                    default: begin
                        err_n = 3'd3;
                        nxt   = DRAIN;
                    end
                endcase
            end
            WAIT: begin
                if (wcnt == WW'(DP_LAT - 1)) nxt = FETCH;
            end
            DRAIN: begin
                // Discard the rest of a failed expression up to and including its end token.
                if (!empty) begin
                    rd_en = 1'b1;
                    if (head[17:16] == K_END) nxt = RESULT;
                end
            end
            RESULT: begin
                if (bus.res_ready) begin
                    nxt     = FETCH;
                    err_n   = 3'd0;
                    depth_n = '0;
                end
            end
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            depth      <= '0;
            err_q      <= '0;
            wcnt       <= '0;
            res_data_q <= '0;
            res_err_q  <= '0;
            dp_clr     <= 1'b0;
            boot       <= 1'b1;
        end else begin
            if (wr_en) wptr <= wptr + PW'(1);
            if (rd_en) rptr <= rptr + PW'(1);
            depth  <= depth_n;
            err_q  <= err_n;
            wcnt   <= (state == WAIT) ? wcnt + WW'(1) : '0;
            // boot makes the first cycle after reset release a stack clear.
            dp_clr <= boot | hs;
            boot   <= 1'b0;
            if (state != RESULT && nxt == RESULT) begin
                res_data_q <= (err_n == 3'd0) ? dp_out : 16'd0;
                res_err_q  <= err_n;
            end else if (hs) begin
                res_data_q <= '0;
                res_err_q  <= '0;
            end
        end
    end

`ifdef RPN_SEQ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ok  <= '0;
            stat_err <= '0;
        end else if (hs) begin
            if (res_err_q == 3'd0) begin
                if (stat_ok != 16'hFFFF) stat_ok <= stat_ok + 16'd1;
            end else if (stat_err != 16'hFFFF) begin
                stat_err <= stat_err + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_rpn_sequencer.sv
// Self-checking bench for rpn_sequencer: vector table, hand-written corner sequences and random expressions
// checked against a queue-based RPN evaluator, with a behavioural stack datapath standing in for the real one.
module tb_rpn_sequencer;
    localparam int DEPTH      = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int DP_LAT     = 2;
    localparam int TMO        = 400;
    localparam int NV         = 12;
    localparam int NR         = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rpn_sequencer_if bus();
    logic        dp_step, dp_push, dp_clr, busy;
    logic [1:0]  dp_op;
    logic [15:0] dp_d, dp_out;
`ifdef RPN_SEQ_STATS_EN
    logic [15:0] stat_ok, stat_err;
`endif

    rpn_sequencer #(.DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH), .DP_LAT(DP_LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .dp_step(dp_step), .dp_push(dp_push), .dp_op(dp_op), .dp_d(dp_d),
        .dp_out(dp_out), .dp_clr(dp_clr), .busy(busy)
`ifdef RPN_SEQ_STATS_EN
        , .stat_ok(stat_ok), .stat_err(stat_err)
`endif
    );

    // Stand-in stack datapath; top of stack appears on dp_out two cycles after the step.
    logic [15:0] dstk [16];
    int          sp = 0;
    logic [15:0] tos, dp_q;
    assign tos    = (sp == 0) ? 16'h0 : dstk[sp-1];
    assign dp_out = dp_q;

    always @(posedge clk) begin
        dp_q <= tos;
        if (dp_clr) sp <= 0;
        else if (dp_step) begin
            if (dp_push) begin
                dstk[sp] <= dp_d;
                sp <= sp + 1;
            end else if (dp_op == 2'd1 && sp >= 1) begin
                dstk[sp-1] <= -dstk[sp-1];
            end else if (dp_op == 2'd2 && sp >= 2) begin
                dstk[sp-2] <= dstk[sp-2] + dstk[sp-1];
                sp <= sp - 1;
            end else if (dp_op == 2'd3 && sp >= 2) begin
                dstk[sp-2] <= dstk[sp-2] * dstk[sp-1];
                sp <= sp - 1;
            end
        end
    end

    int step_cnt = 0, acc_cnt = 0, qual_bad = 0;
    always @(posedge clk) begin
        if (dp_step) step_cnt <= step_cnt + 1;
        if (bus.tok_valid && bus.tok_ready) acc_cnt <= acc_cnt + 1;
        if (!dp_step && (dp_push || dp_op != 2'd0 || dp_d != 16'd0)) qual_bad <= qual_bad + 1;
    end

    int ncmp = 0, nfail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] P(input logic [15:0] v);  return {2'b00, v}; endfunction
    function automatic logic [17:0] O(input logic [1:0] op);  return {2'b01, 14'h2A5, op}; endfunction
    function automatic logic [17:0] E();                      return {2'b10, 16'h0}; endfunction
    function automatic logic [17:0] X();                      return {2'b11, 16'h1234}; endfunction

    // Reference: evaluate one expression from the token rules with a plain queue stack.
    function automatic void ref_eval(input logic [17:0] tq[$], output logic [15:0] d,
                                     output logic [2:0] e, output int st);
        logic [15:0] s[$];
        logic [15:0] a, b, r;
        logic [1:0]  k;
        e = 3'd0; st = 0; d = 16'd0;
        foreach (tq[i]) begin
            k = tq[i][17:16];
            if (k == 2'b10) begin
                if (e == 3'd0 && s.size() != 1) e = 3'd4;
                break;
            end
            if (e != 3'd0) continue;
            if (k == 2'b00) begin
                if (s.size() == DEPTH) e = 3'd2;
                else begin s.push_back(tq[i][15:0]); st++; end
            end else if (k == 2'b01) begin
                if (tq[i][1:0] == 2'd0) st++;
                else if (tq[i][1:0] == 2'd1) begin
                    if (s.size() < 1) e = 3'd1;
                    else begin r = s.pop_back(); s.push_back(16'd0 - r); st++; end
                end else begin
                    if (s.size() < 2) e = 3'd1;
                    else begin
                        b = s.pop_back(); a = s.pop_back();
                        r = (tq[i][1:0] == 2'd2) ? a + b : a * b;
                        s.push_back(r); st++;
                    end
                end
            end else e = 3'd3;
        end
        if (e == 3'd0) d = s[s.size()-1];
    endfunction

    task automatic send(input logic [17:0] t);
        int n = 0;
        @(negedge clk);
        bus.tok_valid = 1'b1;
        bus.tok_data  = t;
        while (!bus.tok_ready && n < TMO) begin @(negedge clk); n++; end
        if (!bus.tok_ready) begin
            check("send_timeout", bus.tok_ready, 1);
            bus.tok_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.tok_valid = 1'b0;
    endtask

    task automatic get_res(output logic [15:0] d, output logic [2:0] e);
        int n = 0;
        @(negedge clk);
        while (!bus.res_valid && n < TMO) begin @(negedge clk); n++; end
        d = bus.res_data;
        e = bus.res_err;
        if (!bus.res_valid) begin
            check("res_timeout", bus.res_valid, 1);
            return;
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
    endtask

    typedef struct packed {
        logic [5:0][17:0] tok;
        logic [3:0]       n;
        logic [15:0]      d;
        logic [2:0]       e;
        logic [3:0]       st;
    } vec_t;

    function automatic vec_t mk(input logic [17:0] t0, t1, t2, t3, t4, t5, input int n,
                                input logic [15:0] d, input logic [2:0] e, input int st);
        vec_t v;
        v.tok = {t5, t4, t3, t2, t1, t0};
        v.n   = 4'(n);
        v.d   = d;
        v.e   = e;
        v.st  = 4'(st);
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [NV];
        logic [17:0] htok [10];
        logic [15:0] hexp_d [4];
        logic [2:0]  hexp_e [4];
        logic [17:0] ex[$];
        logic [17:0] stream[$];
        logic [15:0] rq_d[$];
        logic [2:0]  rq_e[$];
        logic [15:0] d, rd;
        logic [2:0]  e, re;
        logic [17:0] t;
        int          base, abase, st, tot_st, len, r, n;

        vt[0]  = mk(P(3), P(4), O(2), E(), 0, 0, 4, 16'h0007, 0, 3);
        vt[1]  = mk(P(5), O(1), E(), 0, 0, 0, 3, 16'hFFFB, 0, 2);
        vt[2]  = mk(P(2), O(2), P(9), E(), 0, 0, 4, 16'h0000, 1, 1);
        vt[3]  = mk(P(6), P(7), O(3), E(), 0, 0, 4, 16'h002A, 0, 3);
        vt[4]  = mk(P(1), P(2), P(3), P(4), P(5), E(), 6, 16'h0000, 2, 4);
        vt[5]  = mk(E(), 0, 0, 0, 0, 0, 1, 16'h0000, 4, 0);
        vt[6]  = mk(X(), P(1), E(), 0, 0, 0, 3, 16'h0000, 3, 0);
        vt[7]  = mk(P(1), P(2), E(), 0, 0, 0, 3, 16'h0000, 4, 2);
        vt[8]  = mk(O(0), P(16'h8000), P(2), O(3), E(), 0, 5, 16'h0000, 0, 4);
        vt[9]  = mk(P(16'hFFFF), P(2), O(2), O(1), E(), 0, 5, 16'hFFFF, 0, 4);
        vt[10] = mk(O(1), E(), 0, 0, 0, 0, 2, 16'h0000, 1, 0);
        vt[11] = mk(P(7), O(1), O(1), O(0), E(), 0, 5, 16'h0007, 0, 4);

        htok = '{P(1), E(), P(2), P(3), O(2), E(), P(4), O(1), E(), E()};
        hexp_d = '{16'h0001, 16'h0005, 16'hFFFC, 16'h0000};
        hexp_e = '{3'd0, 3'd0, 3'd0, 3'd4};

        bus.tok_valid = 1'b0;
        bus.tok_data  = '0;
        bus.res_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tok_ready", bus.tok_ready, 1);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_err", bus.res_err, 0);
        check("rst_dp_step", dp_step, 0);
        check("rst_dp_clr", dp_clr, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk) check("boot_clr_hi", dp_clr, 1);
        @(negedge clk) check("boot_clr_lo", dp_clr, 0);

        // Vector table
        for (int i = 0; i < NV; i++) begin
            base = step_cnt;
            for (int j = 0; j < int'(vt[i].n); j++) send(vt[i].tok[j]);
            get_res(d, e);
            check($sformatf("v%0d_data", i), d, vt[i].d);
            check($sformatf("v%0d_err", i), e, vt[i].e);
            @(negedge clk);
            check($sformatf("v%0d_clr", i), dp_clr, 1);
            check($sformatf("v%0d_steps", i), step_cnt - base, vt[i].st);
        end

        // Result held while the FIFO fills behind it
        send(P(3));
        send(E());
        n = 0;
        @(negedge clk);
        while (!bus.res_valid && n < TMO) begin @(negedge clk); n++; end
        check("hold_valid0", bus.res_valid, 1);
        abase = acc_cnt;
        fork
            begin
                for (int k = 0; k < 10; k++) send(htok[k]);
            end
            begin
                for (int k = 0; k < 12; k++) begin
                    @(negedge clk);
                    check("hold_valid", bus.res_valid, 1);
                    check("hold_data", bus.res_data, 16'h0003);
                    check("hold_err", bus.res_err, 0);
                end
                check("hold_accepted", acc_cnt - abase, 8);
                check("hold_tok_ready", bus.tok_ready, 0);
                bus.res_ready = 1'b1;
                @(posedge clk);
                #1 bus.res_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    get_res(d, e);
                    check($sformatf("hold_r%0d_data", k), d, hexp_d[k]);
                    check($sformatf("hold_r%0d_err", k), e, hexp_e[k]);
                end
            end
        join
        check("hold_all_accepted", acc_cnt - abase, 10);

        // Reset in the middle of an expression
        send(P(1));
        send(P(2));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_dp_step", dp_step, 0);
        check("mid_rst_res_valid", bus.res_valid, 0);
        check("mid_rst_tok_ready", bus.tok_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_dp_clr", dp_clr, 0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) check("mid_clr_hi", dp_clr, 1);
        @(negedge clk) check("mid_clr_lo", dp_clr, 0);
        base = step_cnt;
        send(P(1));
        send(E());
        get_res(d, e);
        check("mid_data", d, 16'h0001);
        check("mid_err", e, 0);
        check("mid_steps", step_cnt - base, 1);

        // Random expressions streamed against the reference evaluator
        tot_st = 0;
        for (int x = 0; x < NR; x++) begin
            ex.delete();
            len = 0;
            do begin
                r = int'($urandom_range(0, 99));
                if (len == 7 || r >= 85) t = {2'b10, 16'($urandom)};
                else if (r < 45)        t = {2'b00, 16'($urandom)};
                else if (r < 80)        t = {2'b01, 16'($urandom)};
                else                    t = {2'b11, 16'($urandom)};
                ex.push_back(t);
                len++;
            end while (t[17:16] != 2'b10);
            ref_eval(ex, rd, re, st);
            tot_st += st;
            rq_d.push_back(rd);
            rq_e.push_back(re);
            foreach (ex[k]) stream.push_back(ex[k]);
        end
        base = step_cnt;
        fork
            begin
                foreach (stream[k]) send(stream[k]);
            end
            begin
                for (int x = 0; x < NR; x++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    get_res(d, e);
                    check($sformatf("rnd%0d_data", x), d, rq_d[x]);
                    check($sformatf("rnd%0d_err", x), e, rq_e[x]);
                end
            end
        join
        check("rnd_steps", step_cnt - base, tot_st);

        repeat (4) @(negedge clk);
        check("idle_busy", busy, 0);
        check("qualifiers_idle", qual_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
